// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiplier tile sequencer and its APB front end.
// Latency: none (types and constants only).
// Backpressure: none.
package mm_pkg;

  // Default widths for blocks that pass whole tile commands as one bus.
  localparam int MM_ADDR_W = 16;
  localparam int MM_DIM_W  = 16;

  // APB register map shared by the register block and the sequencer.
  localparam int REG_A_BASE = 0;
  localparam int REG_B_BASE = 1;
  localparam int REG_C_BASE = 2;
  localparam int REG_M      = 3;
  localparam int REG_N      = 4;
  localparam int REG_P      = 5;
  localparam int REG_CTRL   = 6;  // a write here produces the start pulse

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } tile_seq_state_t;

  typedef struct packed {
    logic [MM_ADDR_W-1:0] a_addr;
    logic [MM_ADDR_W-1:0] b_addr;
    logic [MM_ADDR_W-1:0] c_addr;
    logic [MM_DIM_W-1:0]  rows;
    logic [MM_DIM_W-1:0]  cols;
    logic [MM_DIM_W-1:0]  k;
    logic                 last;
  } tile_cmd_t;

endpackage

// File: rtl/mm_axis_counter.sv
// Step/limit counter for one tile axis: holds the current offset, flags the final step, clips the extent.
// Latency: offset updates on the clock after clr/step; next-value outputs are combinational so the owner can register them.
// Backpressure: none; advances only when the owner asserts step.
module mm_axis_counter #(
  parameter int STEP  = 16,
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             step,
  input  logic [DIM_W-1:0] limit,
  output logic             wrap,
  output logic [DIM_W-1:0] nxt_offset,
  output logic [DIM_W-1:0] nxt_extent,
  output logic             nxt_wrap
);

  // One bit wider than the dimensions so offset+STEP can never overflow.
  localparam logic [DIM_W:0] STEP_X = (DIM_W+1)'(STEP);

  logic [DIM_W-1:0] offset_q, offset_d;
  logic [DIM_W-1:0] remain;

  // Next offset: clear to zero, or step (returning to zero after the final step).
  always_comb begin
    offset_d = offset_q;
    if (clr) begin
      offset_d = '0;
    end else if (step) begin
      offset_d = wrap ? '0 : offset_q + STEP_X[DIM_W-1:0];
    end
  end

  // Final-step flags and clipped extent of the offset about to be loaded.
  always_comb begin
    wrap       = ({1'b0, offset_q} + STEP_X) >= {1'b0, limit};
    nxt_wrap   = ({1'b0, offset_d} + STEP_X) >= {1'b0, limit};
    remain     = limit - offset_d;
    nxt_extent = ({1'b0, remain} > STEP_X) ? STEP_X[DIM_W-1:0] : remain;
    nxt_offset = offset_d;
  end

  // Offset register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) offset_q <= '0;
    else          offset_q <= offset_d;
  end

endmodule

// File: rtl/mm_tile_sequencer.sv
// Walks C = A*B in array-sized tiles and issues one registered command per tile, then pulses done.
// Latency: start->first cmd 1 cycle; tile_done->next cmd 1 cycle; last tile_done->done 1 cycle.
// Backpressure: command held stable until cmd_ready; next tile waits for tile_done.
module mm_tile_sequencer #(
  parameter int ARRAY_WIDTH  = 16,
  parameter int ARRAY_HEIGHT = 16,
  parameter int ADDR_W       = 16,
  parameter int DIM_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] c_base,
  input  logic [DIM_W-1:0]  m,
  input  logic [DIM_W-1:0]  n,
  input  logic [DIM_W-1:0]  p,
  output logic              busy,
  output logic              done,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_a_addr,
  output logic [ADDR_W-1:0] cmd_b_addr,
  output logic [ADDR_W-1:0] cmd_c_addr,
  output logic [DIM_W-1:0]  cmd_rows,
  output logic [DIM_W-1:0]  cmd_cols,
  output logic [DIM_W-1:0]  cmd_k,
  output logic              cmd_last,
  input  logic              tile_done
);
  import mm_pkg::*;

  tile_seq_state_t state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, cmd_vld_q, cmd_vld_d;
  logic [ADDR_W-1:0] cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d, cmd_c_q, cmd_c_d;
  logic [DIM_W-1:0]  cmd_rows_q, cmd_rows_d, cmd_cols_q, cmd_cols_d, cmd_k_q, cmd_k_d;
  logic              cmd_last_q, cmd_last_d;
  logic [ADDR_W-1:0] b_base_q, b_base_d, a_row_q, a_row_d, c_row_q, c_row_d;
  logic [ADDR_W-1:0] a_step_q, a_step_d, c_step_q, c_step_d;
  logic [DIM_W-1:0]  m_q, m_d, p_q, p_d;

  logic              cnt_clr, col_step, row_step;
  logic              col_wrap, col_nxt_wrap, row_wrap, row_nxt_wrap;
  logic [DIM_W-1:0]  col_nxt_off, col_nxt_ext, row_nxt_ext, unused_row_nxt_off;

  mm_axis_counter #(.STEP(ARRAY_HEIGHT), .DIM_W(DIM_W)) u_rows (
    .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .step(row_step), .limit(m_d),
    .wrap(row_wrap), .nxt_offset(unused_row_nxt_off), .nxt_extent(row_nxt_ext), .nxt_wrap(row_nxt_wrap)
  );

  mm_axis_counter #(.STEP(ARRAY_WIDTH), .DIM_W(DIM_W)) u_cols (
    .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .step(col_step), .limit(p_d),
    .wrap(col_wrap), .nxt_offset(col_nxt_off), .nxt_extent(col_nxt_ext), .nxt_wrap(col_nxt_wrap)
  );

  // Sequencing: latch config on start, hand off per tile, advance row bases on column wrap.
  always_comb begin
    state_d  = state_q;
    b_base_d = b_base_q;
    m_d      = m_q;
    p_d      = p_q;
    cmd_k_d  = cmd_k_q;
    a_row_d  = a_row_q;
    c_row_d  = c_row_q;
    a_step_d = a_step_q;
    c_step_d = c_step_q;
    cnt_clr  = 1'b0;
    col_step = 1'b0;
    row_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          b_base_d = b_base;
          m_d      = m;
          p_d      = p;
          cmd_k_d  = n;
          a_row_d  = a_base;
          c_row_d  = c_base;
          // Row strides are fixed for the run, so compute them once here.
          a_step_d = ADDR_W'(ARRAY_HEIGHT * n);
          c_step_d = ADDR_W'(ARRAY_HEIGHT * p);
          cnt_clr  = 1'b1;
          state_d  = (m == '0 || n == '0 || p == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) state_d = WAIT;
      end
      WAIT: begin
        if (tile_done) begin
          if (row_wrap && col_wrap) begin
            state_d = FIN;
          end else begin
            col_step = 1'b1;
            if (col_wrap) begin
              row_step = 1'b1;
              a_row_d  = a_row_q + a_step_q;
              c_row_d  = c_row_q + c_step_q;
            end
            state_d = ISSUE;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers: a new command is captured only when ISSUE is entered, so it holds while stalled.
  always_comb begin
    cmd_a_d    = cmd_a_q;
    cmd_b_d    = cmd_b_q;
    cmd_c_d    = cmd_c_q;
    cmd_rows_d = cmd_rows_q;
    cmd_cols_d = cmd_cols_q;
    cmd_last_d = cmd_last_q;
    cmd_vld_d  = (state_d == ISSUE);
    done_d     = (state_d == FIN);
    // busy stays up through the idle cycle that follows done.
    busy_d     = (state_q == IDLE) ? start : 1'b1;
    if (state_d == ISSUE && state_q != ISSUE) begin
      cmd_a_d    = a_row_d;
      cmd_b_d    = b_base_d + ADDR_W'(col_nxt_off);
      cmd_c_d    = c_row_d + ADDR_W'(col_nxt_off);
      cmd_rows_d = row_nxt_ext;
      cmd_cols_d = col_nxt_ext;
      cmd_last_d = row_nxt_wrap && col_nxt_wrap;
    end
  end

  // State, configuration and command registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cmd_vld_q  <= 1'b0;
      cmd_a_q    <= '0;
      cmd_b_q    <= '0;
      cmd_c_q    <= '0;
      cmd_rows_q <= '0;
      cmd_cols_q <= '0;
      cmd_k_q    <= '0;
      cmd_last_q <= 1'b0;
      b_base_q   <= '0;
      a_row_q    <= '0;
      c_row_q    <= '0;
      a_step_q   <= '0;
      c_step_q   <= '0;
      m_q        <= '0;
      p_q        <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cmd_vld_q  <= cmd_vld_d;
      cmd_a_q    <= cmd_a_d;
      cmd_b_q    <= cmd_b_d;
      cmd_c_q    <= cmd_c_d;
      cmd_rows_q <= cmd_rows_d;
      cmd_cols_q <= cmd_cols_d;
      cmd_k_q    <= cmd_k_d;
      cmd_last_q <= cmd_last_d;
      b_base_q   <= b_base_d;
      a_row_q    <= a_row_d;
      c_row_q    <= c_row_d;
      a_step_q   <= a_step_d;
      c_step_q   <= c_step_d;
      m_q        <= m_d;
      p_q        <= p_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign cmd_valid  = cmd_vld_q;
  assign cmd_a_addr = cmd_a_q;
  assign cmd_b_addr = cmd_b_q;
  assign cmd_c_addr = cmd_c_q;
  assign cmd_rows   = cmd_rows_q;
  assign cmd_cols   = cmd_cols_q;
  assign cmd_k      = cmd_k_q;
  assign cmd_last   = cmd_last_q;

endmodule
